ex_alu_unit: RTL and testbench
==============================

// Module: ex_alu_unit
// PURPOSE
//  RV32I execute-stage arithmetic block: an alu_control decoder plus the ALU datapath.
//  Decodes alu_op, func3 and func7[5] into a 4-bit ALU control code.
//  Produces the combinational result and the branch-taken mark consumed by stage_ex.
//  Also provides a registered copy of both outputs for pipeline/debug use.
// PARAMETERS
//  XLEN  32  datapath width; shift amount is op_b[$clog2(XLEN)-1:0]
// PORTS
//  clk         in   1     clock, rising edge
//  rst_n       in   1     asynchronous active-low reset
//  alu_op      in   3     class from main decoder (encoding below)
//  func3_code  in   3     instruction[14:12]
//  func7_code  in   1     instruction[30]
//  op_a        in   XLEN  operand A, already forwarded/muxed
//  op_b        in   XLEN  operand B, already forwarded/muxed (imm/4/rs2)
//  valid_i     in   1     capture enable for registered outputs
//  alu_ctrl    out  4     decoded control code (combinational)
//  alu_o       out  XLEN  result (combinational)
//  br_mark     out  1     branch condition true (combinational)
//  alu_o_q     out  XLEN  registered alu_o
//  br_mark_q   out  1     registered br_mark
// BEHAVIOUR
//  Single clock clk; reset rst_n is asynchronous, active-low.
//  alu_op: 000 ADD (ld/st/jal/jalr/lui/auipc), 001 BRANCH, 010 R-type, 011 I-type ALU;
//    101-111 reserved -> ADD.
//  alu_ctrl codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND,
//    A BEQ, B BNE, C BLT, D BGE, E BLTU, F BGEU.
//  R-type func3: 000 ADD/SUB(func7=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR,
//    101 SRL/SRA(func7=1), 110 OR, 111 AND.
//  I-type: same table, but func7 is ignored at func3=000 (ADDI never SUB);
//    func7 is honoured only at 101 (SRLI/SRAI).
//  BRANCH func3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU;
//    010/011 -> BEQ with br_mark forced 0.
//  Arithmetic: ADD/SUB wrap modulo 2^XLEN with no flags.
//    SLT/BLT/BGE use signed compare; SLTU/BLTU/BGEU use unsigned compare.
//  Shifts use op_b[4:0] only, upper bits ignored. SRA replicates op_a[31].
//  SLT/SLTU result is {31'b0, flag}.
//  Branch codes: alu_o = {31'b0, br_mark}. Non-branch codes: br_mark = 0.
//  Combinational path is zero-latency, has no state and is unaffected by reset.
//  Registered path: on posedge clk with valid_i=1, alu_o_q<=alu_o and br_mark_q<=br_mark;
//    valid_i=0 holds both.
//  rst_n low (any time, including mid-operation) clears alu_o_q=0 and br_mark_q=0 at once.
//    Capture resumes on the first posedge after rst_n deasserts.
//  No X propagation: every alu_op/func3/func7 combination maps to a defined code.
// STRUCTURE
//  Shared package/define: alu_op encodings and the 16 alu_ctrl localparams.
//  Sub-module alu_control: pure combinational decoder.
//  Top level: ALU datapath case statement plus output register.
// TESTING
//  R-type: alu_op=010, f3=000, f7=1, a=5, b=7 -> alu_ctrl=1, alu_o=FFFFFFFE, br_mark=0.
//  I-type: alu_op=011, f3=000, f7=1, a=5, b=7 -> ADD, alu_o=0000000C.
//  Shifts: a=80000000, b=00000024 (shamt 4): SRA -> F8000000, SRL -> 08000000.
//  Compare: a=FFFFFFFF, b=1: SLT=1, SLTU=0, BLT br_mark=1, BGEU br_mark=1, BEQ br_mark=0.
//  Register: valid_i pulse captures alu_o; valid_i=0 holds it; rst_n low mid-cycle
//    zeroes alu_o_q/br_mark_q without a clock edge.
//  Reserved: alu_op=111, a=1, b=2 -> ADD, alu_o=3; branch f3=010 -> br_mark=0.

Source files
------------

// File: rtl/ex_alu_unit_pkg.sv
// Shared encodings for the execute-stage ALU: alu_op classes and the 4-bit alu_ctrl codes.
package ex_alu_unit_pkg;

  localparam logic [2:0] ALU_OP_ADD    = 3'b000;
  localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
  localparam logic [2:0] ALU_OP_RTYPE  = 3'b010;
  localparam logic [2:0] ALU_OP_ITYPE  = 3'b011;

  localparam logic [3:0] CTRL_ADD  = 4'h0;
  localparam logic [3:0] CTRL_SUB  = 4'h1;
  localparam logic [3:0] CTRL_SLL  = 4'h2;
  localparam logic [3:0] CTRL_SLT  = 4'h3;
  localparam logic [3:0] CTRL_SLTU = 4'h4;
  localparam logic [3:0] CTRL_XOR  = 4'h5;
  localparam logic [3:0] CTRL_SRL  = 4'h6;
  localparam logic [3:0] CTRL_SRA  = 4'h7;
  localparam logic [3:0] CTRL_OR   = 4'h8;
  localparam logic [3:0] CTRL_AND  = 4'h9;
  localparam logic [3:0] CTRL_BEQ  = 4'hA;
  localparam logic [3:0] CTRL_BNE  = 4'hB;
  localparam logic [3:0] CTRL_BLT  = 4'hC;
  localparam logic [3:0] CTRL_BGE  = 4'hD;
  localparam logic [3:0] CTRL_BLTU = 4'hE;
  localparam logic [3:0] CTRL_BGEU = 4'hF;

  // Branch codes occupy the upper contiguous block A..F.
  function automatic logic is_branch_ctrl(input logic [3:0] ctrl);
    return (ctrl >= CTRL_BEQ);
  endfunction

  // Shared R/I arithmetic table; alt selects SUB at 000 and SRA at 101.
  function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic alt);
    logic [3:0] c;
    case (f3)
      3'b000:  c = alt ? CTRL_SUB : CTRL_ADD;
      3'b001:  c = CTRL_SLL;
      3'b010:  c = CTRL_SLT;
      3'b011:  c = CTRL_SLTU;
      3'b100:  c = CTRL_XOR;
      3'b101:  c = alt ? CTRL_SRA : CTRL_SRL;
      3'b110:  c = CTRL_OR;
      3'b111:  c = CTRL_AND;
      default: c = CTRL_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ex_alu_unit_alu_control.sv
// Combinational alu_control decoder: alu_op/func3/func7[5] to a 4-bit ALU control code.
module ex_alu_unit_alu_control
  import ex_alu_unit_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [2:0] func3_code,
  input  logic       func7_code,
  output logic [3:0] alu_ctrl,
  output logic       br_force_zero
);

  // Decode the instruction class into a control code; undefined branch func3 kills the mark.
  always_comb begin
    alu_ctrl      = CTRL_ADD;
    br_force_zero = 1'b0;
    case (alu_op)
      ALU_OP_RTYPE: alu_ctrl = arith_ctrl(func3_code, func7_code);
      // ADDI never becomes SUB; func7 only distinguishes SRLI/SRAI.
      ALU_OP_ITYPE: alu_ctrl = arith_ctrl(func3_code, func7_code & (func3_code == 3'b101));
      ALU_OP_BRANCH: begin
        case (func3_code)
          3'b000:  alu_ctrl = CTRL_BEQ;
          3'b001:  alu_ctrl = CTRL_BNE;
          3'b100:  alu_ctrl = CTRL_BLT;
          3'b101:  alu_ctrl = CTRL_BGE;
          3'b110:  alu_ctrl = CTRL_BLTU;
          3'b111:  alu_ctrl = CTRL_BGEU;
          default: begin
            alu_ctrl      = CTRL_BEQ;
            br_force_zero = 1'b1;
          end
        endcase
      end
      default: alu_ctrl = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/ex_alu_unit.sv
// RV32I execute-stage ALU: decoder instance, combinational datapath and a valid-gated output register.
module ex_alu_unit
  import ex_alu_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      alu_op,
  input  logic [2:0]      func3_code,
  input  logic            func7_code,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            valid_i,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_o,
  output logic            br_mark,
  output logic [XLEN-1:0] alu_o_q,
  output logic            br_mark_q
);

  localparam int SHW = $clog2(XLEN);

  logic            br_force_zero_s;
  logic [SHW-1:0]  shamt_s;
  logic            lt_s_s;
  logic            lt_u_s;
  logic            cond_s;
  logic [XLEN-1:0] res_s;
  logic [XLEN-1:0] alu_o_r;
  logic            br_mark_r;

  ex_alu_unit_alu_control u_alu_control (
    .alu_op        (alu_op),
    .func3_code    (func3_code),
    .func7_code    (func7_code),
    .alu_ctrl      (alu_ctrl),
    .br_force_zero (br_force_zero_s)
  );

  assign shamt_s = op_b[SHW-1:0];
  assign lt_s_s  = ($signed(op_a) < $signed(op_b));
  assign lt_u_s  = (op_a < op_b);

  // ALU datapath: arithmetic result and raw branch condition for the decoded code.
  always_comb begin
    res_s  = op_a + op_b;
    cond_s = 1'b0;
    case (alu_ctrl)
      CTRL_ADD:  res_s = op_a + op_b;
      CTRL_SUB:  res_s = op_a - op_b;
      CTRL_SLL:  res_s = op_a << shamt_s;
      CTRL_SLT:  res_s = {{(XLEN-1){1'b0}}, lt_s_s};
      CTRL_SLTU: res_s = {{(XLEN-1){1'b0}}, lt_u_s};
      CTRL_XOR:  res_s = op_a ^ op_b;
      CTRL_SRL:  res_s = op_a >> shamt_s;
      CTRL_SRA:  res_s = $unsigned($signed(op_a) >>> shamt_s);
      CTRL_OR:   res_s = op_a | op_b;
      CTRL_AND:  res_s = op_a & op_b;
      CTRL_BEQ:  cond_s = (op_a == op_b);
      CTRL_BNE:  cond_s = (op_a != op_b);
      CTRL_BLT:  cond_s = lt_s_s;
      CTRL_BGE:  cond_s = ~lt_s_s;
      CTRL_BLTU: cond_s = lt_u_s;
      CTRL_BGEU: cond_s = ~lt_u_s;
      default: begin
        res_s  = op_a + op_b;
        cond_s = 1'b0;
      end
    endcase
  end

  assign br_mark = is_branch_ctrl(alu_ctrl) & cond_s & ~br_force_zero_s;
  assign alu_o   = is_branch_ctrl(alu_ctrl) ? {{(XLEN-1){1'b0}}, br_mark} : res_s;

  // Pipeline/debug copy: capture on valid_i, hold otherwise, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_o_r   <= {XLEN{1'b0}};
      br_mark_r <= 1'b0;
    end else if (valid_i) begin
      alu_o_r   <= alu_o;
      br_mark_r <= br_mark;
    end else begin
      alu_o_r   <= alu_o_r;
      br_mark_r <= br_mark_r;
    end
  end

  assign alu_o_q   = alu_o_r;
  assign br_mark_q = br_mark_r;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed self-checking bench for ex_alu_unit with hand-computed expected values.
module tb_ex_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  alu_op;
  logic [2:0]  func3_code;
  logic        func7_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        valid_i;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_o;
  logic        br_mark;
  logic [31:0] alu_o_q;
  logic        br_mark_q;

  int checks;
  int errors;

  ex_alu_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_op     (alu_op),
    .func3_code (func3_code),
    .func7_code (func7_code),
    .op_a       (op_a),
    .op_b       (op_b),
    .valid_i    (valid_i),
    .alu_ctrl   (alu_ctrl),
    .alu_o      (alu_o),
    .br_mark    (br_mark),
    .alu_o_q    (alu_o_q),
    .br_mark_q  (br_mark_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op = op; func3_code = f3; func7_code = f7; op_a = a; op_b = b;
    #1;
  endtask

  task automatic comb(input string tag, input logic [3:0] ctrl, input logic [31:0] res,
                      input logic br);
    chk({tag, "_ctrl"}, {28'd0, ctrl}, {28'd0, ctrl} ^ {28'd0, alu_ctrl} ^ {28'd0, ctrl});
    chk({tag, "_ctrlv"}, {28'd0, alu_ctrl}, {28'd0, ctrl});
    chk({tag, "_res"}, alu_o, res);
    chk({tag, "_br"}, {31'd0, br_mark}, {31'd0, br});
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; valid_i = 1'b0;
    alu_op = 3'b000; func3_code = 3'b000; func7_code = 1'b0;
    op_a = 32'd0; op_b = 32'd0;
    #12;
    chk("rst_alu_o_q", alu_o_q, 32'h0000_0000);
    chk("rst_br_mark_q", {31'd0, br_mark_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type / I-type arithmetic
    drive(3'b010, 3'b000, 1'b1, 32'd5, 32'd7);              comb("r_sub",  4'h1, 32'hFFFF_FFFE, 1'b0);
    drive(3'b010, 3'b000, 1'b0, 32'd5, 32'd7);              comb("r_add",  4'h0, 32'h0000_000C, 1'b0);
    drive(3'b011, 3'b000, 1'b1, 32'd5, 32'd7);              comb("i_addi", 4'h0, 32'h0000_000C, 1'b0);
    drive(3'b011, 3'b001, 1'b1, 32'd3, 32'h0000_0021);      comb("i_slli", 4'h2, 32'h0000_0006, 1'b0);
    drive(3'b011, 3'b100, 1'b1, 32'h0000_F0F0, 32'h0000_FF00); comb("i_xori", 4'h5, 32'h0000_0FF0, 1'b0);
    drive(3'b010, 3'b110, 1'b0, 32'h0000_F0F0, 32'h0000_FF00); comb("r_or",   4'h8, 32'h0000_FFF0, 1'b0);
    drive(3'b010, 3'b111, 1'b0, 32'h0000_F0F0, 32'h0000_FF00); comb("r_and",  4'h9, 32'h0000_F000, 1'b0);

    // Shifts use only op_b[4:0]
    drive(3'b011, 3'b101, 1'b1, 32'h8000_0000, 32'h0000_0024); comb("srai", 4'h7, 32'hF800_0000, 1'b0);
    drive(3'b011, 3'b101, 1'b0, 32'h8000_0000, 32'h0000_0024); comb("srli", 4'h6, 32'h0800_0000, 1'b0);
    drive(3'b010, 3'b101, 1'b1, 32'h8000_0000, 32'h0000_0024); comb("r_sra", 4'h7, 32'hF800_0000, 1'b0);

    // Signed vs unsigned compares, a=-1, b=1
    drive(3'b010, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1); comb("slt",  4'h3, 32'd1, 1'b0);
    drive(3'b010, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1); comb("sltu", 4'h4, 32'd0, 1'b0);
    drive(3'b001, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1); comb("blt",  4'hC, 32'd1, 1'b1);
    drive(3'b001, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1); comb("bgeu", 4'hF, 32'd1, 1'b1);
    drive(3'b001, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1); comb("beq",  4'hA, 32'd0, 1'b0);
    drive(3'b001, 3'b001, 1'b0, 32'hFFFF_FFFF, 32'd1); comb("bne",  4'hB, 32'd1, 1'b1);
    drive(3'b001, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1); comb("bge",  4'hD, 32'd0, 1'b0);
    drive(3'b001, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1); comb("bltu", 4'hE, 32'd0, 1'b0);

    // Reserved encodings
    drive(3'b111, 3'b000, 1'b1, 32'd1, 32'd2);         comb("rsv_op",  4'h0, 32'd3, 1'b0);
    drive(3'b001, 3'b010, 1'b0, 32'd5, 32'd5);         comb("rsv_br2", 4'hA, 32'd0, 1'b0);
    drive(3'b001, 3'b011, 1'b0, 32'd5, 32'd5);         comb("rsv_br3", 4'hA, 32'd0, 1'b0);

    // Registered path: capture, hold, capture, async clear, resume
    drive(3'b010, 3'b000, 1'b1, 32'd5, 32'd7);
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("q_cap_alu", alu_o_q, 32'hFFFF_FFFE);
    chk("q_cap_br", {31'd0, br_mark_q}, 32'd0);
    drive(3'b001, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk); #1;
    chk("q_hold_alu", alu_o_q, 32'hFFFF_FFFE);
    chk("q_hold_br", {31'd0, br_mark_q}, 32'd0);
    valid_i = 1'b1;
    @(posedge clk); #1;
    chk("q_br_alu", alu_o_q, 32'h0000_0001);
    chk("q_br_br", {31'd0, br_mark_q}, 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("q_arst_alu", alu_o_q, 32'h0000_0000);
    chk("q_arst_br", {31'd0, br_mark_q}, 32'd0);
    drive(3'b111, 3'b000, 1'b0, 32'd1, 32'd2);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("q_resume_alu", alu_o_q, 32'h0000_0003);
    chk("q_resume_br", {31'd0, br_mark_q}, 32'd0);
    valid_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
